csr_tohost_ctrl: RTL and testbench
==================================

CSR_TOHOST_CTRL -- requirements
Module: csr_tohost_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving tohost FIFO entries; legal values are powers of two from 2 to 16.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port csr_we  input  1  pipeline CSR write request, requester 0.
REQ-005 SHALL have port csr_funct3  input  3  instr[14:12] of the requesting CSR instruction.
REQ-006 SHALL have ports csr_rs1 and csr_imm  input  32  each; register operand and extended immediate.
REQ-007 SHALL have port dbg_we  input  1  debug write request, requester 1.
REQ-008 SHALL have port dbg_wdata  input  32  debug write value.
REQ-009 SHALL have port csr_stall  output  1  pipeline must hold its CSR instruction.
REQ-010 SHALL have port dbg_gnt  output  1  debug write accepted this cycle.
REQ-011 SHALL have ports host_valid  output  1, host_data  output  32, host_ready  input  1; host drain handshake.
REQ-012 SHALL have ports done  output  1, pass  output  1, fail_code  output  31  test termination status.

Function
REQ-013 Write value SHALL be csr_rs1 when csr_funct3=001, csr_imm when 101, 32'h0 for any other code.
REQ-014 In RUN, both requesters contending SHALL be arbitrated round-robin; after reset requester 0 has priority.
REQ-015 A requester SHALL be granted only when the FIFO is not full and the state is RUN.
REQ-016 A grant SHALL push the selected value in the same cycle; it is visible on host_data no earlier than the next cycle.
REQ-017 csr_stall SHALL be combinational: csr_we=1 and requester 0 not granted this cycle.
REQ-018 dbg_gnt SHALL be combinational: dbg_we=1 and requester 1 granted this cycle.
REQ-019 Full SHALL block a push even if a pop occurs in the same cycle.
REQ-020 When not empty and not full, a simultaneous push and pop SHALL both occur and leave occupancy unchanged.
REQ-021 host_valid SHALL equal "FIFO not empty"; host_data SHALL show the oldest entry.
REQ-022 A pop SHALL occur exactly when host_valid and host_ready are both 1.
REQ-023 host_data SHALL remain stable while host_valid=1 and host_ready=0.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked in log2(DEPTH)+1 bits.
REQ-025 State machine states SHALL be RUN, DRAIN and HALT.
REQ-026 RUN SHALL go to DRAIN on a push whose value has bit0=1.
REQ-027 In DRAIN, there SHALL be no grants; csr_stall follows csr_we and dbg_gnt=0.
REQ-028 DRAIN SHALL go to HALT in the cycle after the FIFO becomes empty.
REQ-029 HALT SHALL be sticky until reset; grants stay blocked in HALT.
REQ-030 On entry to DRAIN, the terminal value SHALL be latched.
REQ-031 In HALT, done=1, pass=(latched value==1), and fail_code=latched value[31:1].
REQ-032 Outside HALT, done, pass and fail_code SHALL be 0.
REQ-033 A value of 0 or an even value SHALL be queued normally and SHALL NOT terminate the test.

Reset
REQ-034 While rst=1, the FIFO SHALL be emptied and the state forced to RUN.
REQ-035 While rst=1, the round-robin pointer SHALL favour requester 0 and the latched value SHALL be 0.
REQ-036 While rst=1, host_valid, host_data, done, pass and fail_code SHALL all be 0.
REQ-037 Reset asserted mid-drain or mid-handshake SHALL discard all queued entries without a pop.

Structure
REQ-038 The state enum, funct3 codes 001/101 and pass code 32'h1 SHALL live in a shared package, csr_pkg.
REQ-039 The FIFO SHALL be one sub-module, tohost_fifo, with push/pop/full/empty ports; arbitration and the state machine stay in csr_tohost_ctrl.

Verification
REQ-040 csr_we=1, funct3=001, rs1=32'h00000010, host_ready=1 -> next cycle host_valid=1, host_data=32'h10; state stays RUN.
REQ-041 csr_we and dbg_we both held high for 4 cycles (funct3=101, imm=32'h2; dbg_wdata=32'h4), host_ready=1 -> grants alternate csr, dbg, csr, dbg; csr_stall=1 on cycles 2 and 4 only.
REQ-042 host_ready=0 with 5 csr pushes, DEPTH=4 -> csr_stall=1 on the 5th; host_data holds the first value until host_ready rises.
REQ-043 At full, push and pop in the same cycle -> pop occurs, push is refused, occupancy becomes 3.
REQ-044 Push 32'h2A, then 32'h1, host_ready=1 -> DRAIN, then HALT one cycle after empty; done=1, pass=1, fail_code=0.
REQ-045 Push 32'h7 -> fail_code=3, pass=0; rst pulsed while in DRAIN with 2 entries queued -> host_valid=0, done=0, state RUN.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared definitions for the tohost controller: state encoding, CSR write
// function codes, the pass code and the write-value selection helper.
package csr_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    localparam logic [2:0]  FUNCT3_CSRRW  = 3'b001;
    localparam logic [2:0]  FUNCT3_CSRRWI = 3'b101;
    localparam logic [31:0] PASS_CODE     = 32'h0000_0001;

    // Only the plain register and immediate write forms carry a payload.
    function automatic logic [31:0] csr_wval(input logic [2:0]  funct3,
                                             input logic [31:0] rs1,
                                             input logic [31:0] imm);
        logic [31:0] val;
        case (funct3)
            FUNCT3_CSRRW:  val = rs1;
            FUNCT3_CSRRWI: val = imm;
            default:       val = 32'h0000_0000;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/tohost_fifo.sv
// Power-of-two circular FIFO holding tohost words; full refuses pushes even
// when a pop happens in the same cycle.
module tohost_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  logic [31:0] push_data_i,
    input  logic        pop_i,
    output logic        full_o,
    output logic        empty_o,
    output logic [31:0] head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == {CW{1'b0}});
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;
    assign head_o    = empty_o ? 32'h0000_0000 : mem_q[rd_ptr_q];

    // Occupancy next-state from the accepted push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/csr_tohost_ctrl.sv
// tohost controller: round-robin arbitration between the pipeline CSR write
// and the debug port, a drain FIFO to the host, and the RUN/DRAIN/HALT FSM.
module csr_tohost_ctrl
    import csr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_we,
    input  logic [2:0]  csr_funct3,
    input  logic [31:0] csr_rs1,
    input  logic [31:0] csr_imm,
    input  logic        dbg_we,
    input  logic [31:0] dbg_wdata,
    output logic        csr_stall,
    output logic        dbg_gnt,
    output logic        host_valid,
    output logic [31:0] host_data,
    input  logic        host_ready,
    output logic        done,
    output logic        pass,
    output logic [30:0] fail_code
);

    state_e      state_q;
    logic        rr_q;
    logic [31:0] term_q;

    logic [31:0] csr_val_s;
    logic [31:0] push_val_s;
    logic        gnt0_s;
    logic        gnt1_s;
    logic        push_s;
    logic        pop_s;
    logic        full_s;
    logic        empty_s;
    logic        can_gnt_s;
    logic        halt_s;

    assign csr_val_s = csr_wval(csr_funct3, csr_rs1, csr_imm);
    assign can_gnt_s = (state_q == ST_RUN) & ~full_s;

    // rr_q=1 means the debug port wins the next contended cycle.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (can_gnt_s) begin
            if (csr_we && dbg_we) begin
                gnt0_s = ~rr_q;
                gnt1_s = rr_q;
            end else begin
                gnt0_s = csr_we;
                gnt1_s = dbg_we;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign push_s     = gnt0_s | gnt1_s;
    assign push_val_s = gnt1_s ? dbg_wdata : csr_val_s;
    assign pop_s      = host_valid & host_ready;
    assign csr_stall  = csr_we & ~gnt0_s;
    assign dbg_gnt    = dbg_we & gnt1_s;
    assign host_valid = ~empty_s;

    tohost_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push_s),
        .push_data_i(push_val_s),
        .pop_i      (pop_s),
        .full_o     (full_s),
        .empty_o    (empty_s),
        .head_o     (host_data)
    );

    // Run/drain/halt sequencing, round-robin pointer and terminal value latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            rr_q    <= 1'b0;
            term_q  <= 32'h0000_0000;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (push_s) begin
                        rr_q <= gnt0_s;
                    end
                    if (push_s && push_val_s[0]) begin
                        state_q <= ST_DRAIN;
                        term_q  <= push_val_s;
                    end
                end
                ST_DRAIN: begin
                    if (empty_s) begin
                        state_q <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign halt_s    = (state_q == ST_HALT);
    assign done      = halt_s;
    assign pass      = halt_s & (term_q == PASS_CODE);
    assign fail_code = halt_s ? term_q[31:1] : 31'd0;

endmodule

// File: tb/tb_csr_tohost_ctrl.sv
// Scenario bench for csr_tohost_ctrl: expected words go into a scoreboard
// queue at grant time and are compared when the host pops them.
module tb_csr_tohost_ctrl;

    logic        clk;
    logic        rst;
    logic        csr_we;
    logic [2:0]  csr_funct3;
    logic [31:0] csr_rs1;
    logic [31:0] csr_imm;
    logic        dbg_we;
    logic [31:0] dbg_wdata;
    logic        csr_stall;
    logic        dbg_gnt;
    logic        host_valid;
    logic [31:0] host_data;
    logic        host_ready;
    logic        done;
    logic        pass;
    logic [30:0] fail_code;

    int          cmp_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] sb_q[$];
    logic [31:0] mon_exp;

    csr_tohost_ctrl #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .csr_we    (csr_we),
        .csr_funct3(csr_funct3),
        .csr_rs1   (csr_rs1),
        .csr_imm   (csr_imm),
        .dbg_we    (dbg_we),
        .dbg_wdata (dbg_wdata),
        .csr_stall (csr_stall),
        .dbg_gnt   (dbg_gnt),
        .host_valid(host_valid),
        .host_data (host_data),
        .host_ready(host_ready),
        .done      (done),
        .pass      (pass),
        .fail_code (fail_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, wanted end of tests");
        $fatal(1, "watchdog");
    end

    // Pop monitor: a handshake seen at the falling edge pops on the next rising edge.
    always @(negedge clk) begin
        if (rst === 1'b0 && host_valid === 1'b1 && host_ready === 1'b1) begin
            cmp_cnt++;
            if (sb_q.size() == 0) begin
                err_cnt++;
                $display("FAIL sb_pop: got host_data=%h, wanted no pending entry", host_data);
            end else begin
                mon_exp = sb_q.pop_front();
                if (host_data !== mon_exp) begin
                    err_cnt++;
                    $display("FAIL sb_data: got %h, wanted %h", host_data, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        csr_we = 1'b0;
        dbg_we = 1'b0;
        host_ready = 1'b0;
        sb_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        csr_we = 1'b0; csr_funct3 = 3'b000; csr_rs1 = 32'h0; csr_imm = 32'h0;
        dbg_we = 1'b0; dbg_wdata = 32'h0; host_ready = 1'b0;
        tick();
        tick();
        cmp_cnt++;
        if ({host_valid, host_data, done, pass, fail_code, csr_stall, dbg_gnt} !== 68'd0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got v=%b d=%h done=%b pass=%b fc=%h, wanted all 0",
                     host_valid, host_data, done, pass, fail_code);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        host_ready = 1'b1;
        csr_we = 1'b1; csr_funct3 = 3'b001; csr_rs1 = 32'h10; csr_imm = 32'h0;
        #1;
        cmp_cnt++;
        if (csr_stall !== 1'b0) begin
            err_cnt++; $display("FAIL single_stall: got %b, wanted 0", csr_stall);
        end
        sb_q.push_back(32'h10);
        tick();
        csr_we = 1'b0;
        #1;
        cmp_cnt++;
        if (host_valid !== 1'b1 || host_data !== 32'h10 || done !== 1'b0) begin
            err_cnt++;
            $display("FAIL single_out: got v=%b d=%h done=%b, wanted v=1 d=00000010 done=0",
                     host_valid, host_data, done);
        end
        tick();
        cmp_cnt++;
        if (host_valid !== 1'b0) begin
            err_cnt++; $display("FAIL single_empty: got valid=%b, wanted 0", host_valid);
        end
    endtask

    task automatic test_funct3();
        logic [2:0]  f3_t  [4] = '{3'b010, 3'b101, 3'b001, 3'b111};
        logic [31:0] rs1_t [4] = '{32'h55, 32'h0F, 32'h30, 32'h31};
        logic [31:0] imm_t [4] = '{32'h11, 32'h44, 32'h21, 32'h13};
        logic [31:0] exp_t [4] = '{32'h0, 32'h44, 32'h30, 32'h0};
        host_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            csr_we = 1'b1; csr_funct3 = f3_t[i]; csr_rs1 = rs1_t[i]; csr_imm = imm_t[i];
            #1;
            cmp_cnt++;
            if (csr_stall !== 1'b0) begin
                err_cnt++; $display("FAIL f3_stall[%0d]: got %b, wanted 0", i, csr_stall);
            end
            sb_q.push_back(exp_t[i]);
            tick();
        end
        csr_we = 1'b0;
        tick();
        tick();
        cmp_cnt++;
        if (host_valid !== 1'b0 || done !== 1'b0 || sb_q.size() != 0) begin
            err_cnt++;
            $display("FAIL f3_end: got v=%b done=%b pending=%0d, wanted 0 0 0",
                     host_valid, done, sb_q.size());
        end
    endtask

    task automatic test_rr();
        logic exp_dbg;
        do_reset();
        host_ready = 1'b1;
        csr_we = 1'b1; csr_funct3 = 3'b101; csr_imm = 32'h2; csr_rs1 = 32'h0;
        dbg_we = 1'b1; dbg_wdata = 32'h4;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_dbg = (i % 2 == 1);
            cmp_cnt++;
            if (csr_stall !== exp_dbg || dbg_gnt !== exp_dbg) begin
                err_cnt++;
                $display("FAIL rr_cycle%0d: got stall=%b gnt=%b, wanted stall=%b gnt=%b",
                         i + 1, csr_stall, dbg_gnt, exp_dbg, exp_dbg);
            end
            sb_q.push_back(exp_dbg ? 32'h4 : 32'h2);
            tick();
        end
        csr_we = 1'b0; dbg_we = 1'b0;
        tick();
        tick();
        cmp_cnt++;
        if (host_valid !== 1'b0 || sb_q.size() != 0) begin
            err_cnt++;
            $display("FAIL rr_end: got v=%b pending=%0d, wanted 0 0", host_valid, sb_q.size());
        end
    endtask

    task automatic test_full();
        do_reset();
        host_ready = 1'b0;
        csr_we = 1'b1; csr_funct3 = 3'b001; csr_imm = 32'h0;
        for (int i = 0; i < 4; i++) begin
            csr_rs1 = 32'h100 + 32'(2 * i);
            #1;
            cmp_cnt++;
            if (csr_stall !== 1'b0) begin
                err_cnt++; $display("FAIL full_fill[%0d]: got stall=%b, wanted 0", i, csr_stall);
            end
            sb_q.push_back(csr_rs1);
            tick();
        end
        csr_rs1 = 32'h108;
        for (int i = 0; i < 2; i++) begin
            #1;
            cmp_cnt++;
            if (csr_stall !== 1'b1 || host_data !== 32'h100) begin
                err_cnt++;
                $display("FAIL full_hold[%0d]: got stall=%b d=%h, wanted stall=1 d=00000100",
                         i, csr_stall, host_data);
            end
            tick();
        end
        host_ready = 1'b1;
        #1;
        cmp_cnt++;
        if (csr_stall !== 1'b1) begin
            err_cnt++; $display("FAIL full_pushpop_stall: got %b, wanted 1", csr_stall);
        end
        tick();
        host_ready = 1'b0; csr_we = 1'b0;
        #1;
        cmp_cnt++;
        if (host_data !== 32'h102) begin
            err_cnt++; $display("FAIL full_after_pop: got %h, wanted 00000102", host_data);
        end
        csr_we = 1'b1; csr_rs1 = 32'h10A;
        #1;
        cmp_cnt++;
        if (csr_stall !== 1'b0) begin
            err_cnt++; $display("FAIL full_occ3_push: got stall=%b, wanted 0", csr_stall);
        end
        sb_q.push_back(32'h10A);
        tick();
        cmp_cnt++;
        if (csr_stall !== 1'b1) begin
            err_cnt++; $display("FAIL full_refull: got stall=%b, wanted 1", csr_stall);
        end
        csr_we = 1'b0; host_ready = 1'b1;
        repeat (4) tick();
        cmp_cnt++;
        if (host_valid !== 1'b0 || sb_q.size() != 0) begin
            err_cnt++;
            $display("FAIL full_drain: got v=%b pending=%0d, wanted 0 0", host_valid, sb_q.size());
        end
    endtask

    task automatic test_pass();
        do_reset();
        host_ready = 1'b1;
        csr_we = 1'b1; csr_funct3 = 3'b001; csr_rs1 = 32'h2A;
        sb_q.push_back(32'h2A);
        tick();
        csr_rs1 = 32'h1;
        sb_q.push_back(32'h1);
        tick();
        dbg_we = 1'b1; dbg_wdata = 32'h6;
        #1;
        cmp_cnt++;
        if (csr_stall !== 1'b1 || dbg_gnt !== 1'b0 || done !== 1'b0 || host_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL pass_drain: got stall=%b gnt=%b done=%b v=%b, wanted 1 0 0 1",
                     csr_stall, dbg_gnt, done, host_valid);
        end
        tick();
        cmp_cnt++;
        if (host_valid !== 1'b0 || done !== 1'b0 || csr_stall !== 1'b1) begin
            err_cnt++;
            $display("FAIL pass_empty: got v=%b done=%b stall=%b, wanted 0 0 1",
                     host_valid, done, csr_stall);
        end
        tick();
        cmp_cnt++;
        if (done !== 1'b1 || pass !== 1'b1 || fail_code !== 31'd0 || dbg_gnt !== 1'b0) begin
            err_cnt++;
            $display("FAIL pass_halt: got done=%b pass=%b fc=%h gnt=%b, wanted 1 1 0 0",
                     done, pass, fail_code, dbg_gnt);
        end
        tick();
        tick();
        cmp_cnt++;
        if (done !== 1'b1 || csr_stall !== 1'b1 || host_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL pass_sticky: got done=%b stall=%b v=%b, wanted 1 1 0",
                     done, csr_stall, host_valid);
        end
        csr_we = 1'b0; dbg_we = 1'b0;
    endtask

    task automatic test_fail_reset();
        do_reset();
        host_ready = 1'b1;
        csr_we = 1'b1; csr_funct3 = 3'b001; csr_rs1 = 32'h7;
        sb_q.push_back(32'h7);
        tick();
        csr_we = 1'b0;
        repeat (2) tick();
        cmp_cnt++;
        if (done !== 1'b1 || pass !== 1'b0 || fail_code !== 31'd3) begin
            err_cnt++;
            $display("FAIL fail_halt: got done=%b pass=%b fc=%0d, wanted 1 0 3",
                     done, pass, fail_code);
        end
        do_reset();
        host_ready = 1'b0;
        csr_we = 1'b1; csr_rs1 = 32'h8;
        sb_q.push_back(32'h8);
        tick();
        csr_rs1 = 32'h9;
        sb_q.push_back(32'h9);
        tick();
        csr_rs1 = 32'h20;
        #1;
        cmp_cnt++;
        if (csr_stall !== 1'b1 || host_valid !== 1'b1 || host_data !== 32'h8 || done !== 1'b0) begin
            err_cnt++;
            $display("FAIL drain_q2: got stall=%b v=%b d=%h done=%b, wanted 1 1 00000008 0",
                     csr_stall, host_valid, host_data, done);
        end
        rst = 1'b1;
        host_ready = 1'b1;
        sb_q.delete();
        #1;
        cmp_cnt++;
        if (host_valid !== 1'b0 || host_data !== 32'h0 || done !== 1'b0 ||
            pass !== 1'b0 || fail_code !== 31'd0) begin
            err_cnt++;
            $display("FAIL rst_mid_drain: got v=%b d=%h done=%b pass=%b fc=%h, wanted all 0",
                     host_valid, host_data, done, pass, fail_code);
        end
        tick();
        rst = 1'b0;
        host_ready = 1'b0;
        #1;
        cmp_cnt++;
        if (csr_stall !== 1'b0 || host_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_back_to_run: got stall=%b v=%b, wanted 0 0", csr_stall, host_valid);
        end
        sb_q.push_back(32'h20);
        tick();
        csr_we = 1'b0;
        #1;
        cmp_cnt++;
        if (host_valid !== 1'b1 || host_data !== 32'h20) begin
            err_cnt++;
            $display("FAIL rst_fresh_head: got v=%b d=%h, wanted 1 00000020", host_valid, host_data);
        end
        host_ready = 1'b1;
        tick();
        tick();
        cmp_cnt++;
        if (host_valid !== 1'b0 || sb_q.size() != 0 || done !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_final: got v=%b pending=%0d done=%b, wanted 0 0 0",
                     host_valid, sb_q.size(), done);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_funct3();
        test_rr();
        test_full();
        test_pass();
        test_fail_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
